reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
//
// PURPOSE
//   Multi-port register file for the CPU datapath. It is the parametrised successor
//   to the single-write/dual-read register file.
//   - Configurable word width, register count and read-port count.
//   - Two write ports.
//   - Registered (synchronous) reads with write-to-read bypass.
//   - Optional hardwired zero register.
//   - Asynchronous clear of all state.
//   Sits between decode (addresses) and execute (operands); writeback drives the write ports.
//
// PARAMETERS
//   n        32  data word width in bits
//   r        7   address width; register count = 2**r
//   RP       2   number of read ports (1..4)
//   ZERO_REG 1   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
//
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   resetN      in   1      asynchronous, active-low reset
//   writeEnable in   2      per-write-port enable; bit k for port k
//   writeAddr   in   2*r    port k address = writeAddr[k*r +: r]
//   writeData   in   2*n    port k data = writeData[k*n +: n]
//   readEn      in   RP     per-read-port enable; bit j for port j
//   readAddr    in   RP*r   port j address = readAddr[j*r +: r]
//   readData    out  RP*n   port j data = readData[j*n +: n]; registered
//
// BEHAVIOUR
//   Reset
//   - resetN=0 immediately, without waiting for clk, clears all 2**r registers and all
//     readData words to 0.
//   - No writes or reads take effect while resetN=0.
//   - The first rising edge with resetN=1 is a normal operating edge.
//   - Reset asserted mid-operation discards any same-cycle write.
//
//   Writes
//   - On rising edge, for each k with writeEnable[k]=1: registers[writeAddr_k] <= writeData_k.
//   - Both ports enabled with the same address: port 1 wins; port 0's write is dropped.
//   - ZERO_REG=1 and writeAddr_k=0: that port's write is ignored.
//
//   Reads
//   - 1-cycle latency. On rising edge, for each j with readEn[j]=1, readData_j <= value
//     of registers[readAddr_j] as seen through bypass.
//   - readEn[j]=0: readData_j holds its previous value.
//   - Bypass: if a write port targets readAddr_j on the same edge, readData_j takes that
//     write's data, not the stale array value.
//   - Bypass priority matches write priority: port 1 over port 0.
//   - ZERO_REG=1 and readAddr_j=0: readData_j <= 0, regardless of any write or bypass.
//   - Read ports are independent. Any number may address the same register; each gets
//     an identical value.
//
//   State / width rules
//   - No FSM. State = register array (2**r x n) plus RP output registers.
//   - Addresses are r bits, so every address is valid; there is no out-of-range case.
//   - No combinational path from any input to readData.
//
// TESTING
//   1 Reset: load r5=32'hDEAD_BEEF; drop resetN mid-cycle -> readData all 0 before the next
//     clk edge; after release, reading r5 -> 0.
//   2 Basic: write r3=32'h1234_5678 (port 0); next cycle read r3 on ports 0,1
//     -> both 32'h1234_5678 one edge later.
//   3 Bypass: same edge, write r7=32'hA5A5_A5A5 and read r7 -> readData 32'hA5A5_A5A5
//     after that edge, not the old value 0.
//   4 Write collision: port0 r9=32'h1111_1111, port1 r9=32'h2222_2222 same edge; read r9
//     same edge and next -> 32'h2222_2222 both times.
//   5 Zero register (ZERO_REG=1): write r0=32'hFFFF_FFFF, same-edge read and later read of r0
//     -> 0 both; repeat with ZERO_REG=0 -> 32'hFFFF_FFFF.
//   6 Hold/params: readEn=0 while r3 changes -> readData unchanged. Rerun tests 2-4 with
//     n=64, r=5, RP=4 -> same results on all four ports.

Source files
------------

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Multi-port register file with two write ports, registered reads,
//            write-to-read bypass and an optional hardwired zero register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_mp #(
    parameter int n        = 32,
    parameter int r        = 7,
    parameter int RP       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [1:0]        writeEnable,
    input  logic [2*r-1:0]    writeAddr,
    input  logic [2*n-1:0]    writeData,
    input  logic [RP-1:0]     readEn,
    input  logic [RP*r-1:0]   readAddr,
    output logic [RP*n-1:0]   readData
);

    localparam int NREGS = 2 ** r;

    logic [r-1:0] wr_addr0;
    logic [r-1:0] wr_addr1;
    logic [n-1:0] wr_data0;
    logic [n-1:0] wr_data1;
    logic         wr_ok0;
    logic         wr_ok1;

    assign wr_addr0 = writeAddr[0 +: r];
    assign wr_addr1 = writeAddr[r +: r];
    assign wr_data0 = writeData[0 +: n];
    assign wr_data1 = writeData[n +: n];

    // A write to register 0 is suppressed entirely when it is hardwired to zero.
    assign wr_ok0 = writeEnable[0] && !((ZERO_REG != 0) && (wr_addr0 == '0));
    assign wr_ok1 = writeEnable[1] && !((ZERO_REG != 0) && (wr_addr1 == '0));

    logic [n-1:0] regs [NREGS];

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_reg
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    regs[i] <= '0;
                end else if (wr_ok1 && (wr_addr1 == r'(i))) begin
                    regs[i] <= wr_data1;
                end else if (wr_ok0 && (wr_addr0 == r'(i))) begin
                    regs[i] <= wr_data0;
                end
            end
        end
    endgenerate

    logic [n-1:0] rd_q [RP];

    generate
        for (genvar j = 0; j < RP; j++) begin : g_rd
            logic [r-1:0] rd_addr;
            logic [n-1:0] rd_next;

            assign rd_addr = readAddr[j*r +: r];

            // Port 1 is checked last so it overrides port 0, matching write priority.
            always_comb begin
                rd_next = regs[rd_addr];
                if (wr_ok0 && (wr_addr0 == rd_addr)) begin
                    rd_next = wr_data0;
                end
                if (wr_ok1 && (wr_addr1 == rd_addr)) begin
                    rd_next = wr_data1;
                end
                if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                    rd_next = '0;
                end
            end

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    rd_q[j] <= '0;
                end else if (readEn[j]) begin
                    rd_q[j] <= rd_next;
                end
            end

            assign readData[j*n +: n] = rd_q[j];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Directed self-checking bench for reg_file_mp in three configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    // Default configuration (n=32, r=7, RP=2, ZERO_REG=1)
    logic [1:0]  a_we;
    logic [13:0] a_wa;
    logic [63:0] a_wd;
    logic [1:0]  a_re;
    logic [13:0] a_ra;
    logic [63:0] a_rd;

    // Same stimulus, ZERO_REG=0
    logic [63:0] z_rd;

    // Wide configuration (n=64, r=5, RP=4)
    logic [1:0]   w_we;
    logic [9:0]   w_wa;
    logic [127:0] w_wd;
    logic [3:0]   w_re;
    logic [19:0]  w_ra;
    logic [255:0] w_rd;

    int n_assert = 0;
    int n_fail   = 0;

    reg_file_mp #(.n(32), .r(7), .RP(2), .ZERO_REG(1)) u_a (
        .clk(clk), .resetN(resetN),
        .writeEnable(a_we), .writeAddr(a_wa), .writeData(a_wd),
        .readEn(a_re), .readAddr(a_ra), .readData(a_rd)
    );

    reg_file_mp #(.n(32), .r(7), .RP(2), .ZERO_REG(0)) u_z (
        .clk(clk), .resetN(resetN),
        .writeEnable(a_we), .writeAddr(a_wa), .writeData(a_wd),
        .readEn(a_re), .readAddr(a_ra), .readData(z_rd)
    );

    reg_file_mp #(.n(64), .r(5), .RP(4), .ZERO_REG(1)) u_w (
        .clk(clk), .resetN(resetN),
        .writeEnable(w_we), .writeAddr(w_wa), .writeData(w_wd),
        .readEn(w_re), .readAddr(w_ra), .readData(w_rd)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_we = '0; a_wa = '0; a_wd = '0; a_re = '0; a_ra = '0;
    endtask

    task automatic a_wr(input int port, input logic [6:0] addr, input logic [31:0] data);
        a_we[port]          = 1'b1;
        a_wa[port*7 +: 7]   = addr;
        a_wd[port*32 +: 32] = data;
    endtask

    task automatic a_rd_all(input logic [6:0] addr);
        a_re = 2'b11;
        a_ra = {addr, addr};
    endtask

    task automatic w_idle();
        w_we = '0; w_wa = '0; w_wd = '0; w_re = '0; w_ra = '0;
    endtask

    task automatic w_wr(input int port, input logic [4:0] addr, input logic [63:0] data);
        w_we[port]          = 1'b1;
        w_wa[port*5 +: 5]   = addr;
        w_wd[port*64 +: 64] = data;
    endtask

    task automatic w_rd_all(input logic [4:0] addr);
        w_re = 4'hF;
        w_ra = {addr, addr, addr, addr};
    endtask

    task automatic w_check(input string tag, input logic [63:0] exp);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_p%0d", tag, j), w_rd[j*64 +: 64], exp);
        end
    endtask

    initial begin
        resetN = 1'b0;
        a_idle();
        w_idle();
        repeat (2) step();
        check("rst_a_p0", {32'h0, a_rd[31:0]}, 64'h0);
        check("rst_a_p1", {32'h0, a_rd[63:32]}, 64'h0);
        w_check("rst_w", 64'h0);
        resetN = 1'b1;

        // Asynchronous clear while readData holds a live value
        a_wr(0, 7'd5, 32'hDEAD_BEEF);
        step();
        a_idle(); a_rd_all(7'd5);
        step();
        check("pre_rst_r5", {32'h0, a_rd[31:0]}, 64'h0000_0000_DEAD_BEEF);
        #2 resetN = 1'b0;
        #1;
        check("async_rst_p0", {32'h0, a_rd[31:0]}, 64'h0);
        check("async_rst_p1", {32'h0, a_rd[63:32]}, 64'h0);
        a_wr(0, 7'd5, 32'h5555_5555);
        step();
        check("rst_no_read", {32'h0, a_rd[31:0]}, 64'h0);
        resetN = 1'b1;
        a_idle(); a_rd_all(7'd5);
        step();
        check("post_rst_r5", {32'h0, a_rd[31:0]}, 64'h0);

        // Basic write then read
        a_idle(); a_wr(0, 7'd3, 32'h1234_5678);
        step();
        a_idle(); a_rd_all(7'd3);
        step();
        check("basic_p0", {32'h0, a_rd[31:0]}, 64'h1234_5678);
        check("basic_p1", {32'h0, a_rd[63:32]}, 64'h1234_5678);

        // Same-edge bypass
        a_idle(); a_wr(0, 7'd7, 32'hA5A5_A5A5); a_rd_all(7'd7);
        step();
        check("bypass_p0", {32'h0, a_rd[31:0]}, 64'hA5A5_A5A5);
        check("bypass_p1", {32'h0, a_rd[63:32]}, 64'hA5A5_A5A5);

        // Write collision: port 1 wins
        a_idle(); a_wr(0, 7'd9, 32'h1111_1111); a_wr(1, 7'd9, 32'h2222_2222); a_rd_all(7'd9);
        step();
        check("coll_byp_p0", {32'h0, a_rd[31:0]}, 64'h2222_2222);
        check("coll_byp_p1", {32'h0, a_rd[63:32]}, 64'h2222_2222);
        a_idle(); a_rd_all(7'd9);
        step();
        check("coll_arr_p0", {32'h0, a_rd[31:0]}, 64'h2222_2222);
        check("coll_arr_p1", {32'h0, a_rd[63:32]}, 64'h2222_2222);

        // Zero register vs ordinary register 0
        a_idle(); a_wr(0, 7'd0, 32'hFFFF_FFFF); a_rd_all(7'd0);
        step();
        check("zero_byp_a", {32'h0, a_rd[31:0]}, 64'h0);
        check("zero_byp_z", {32'h0, z_rd[31:0]}, 64'hFFFF_FFFF);
        a_idle(); a_rd_all(7'd0);
        step();
        check("zero_arr_a", {32'h0, a_rd[63:32]}, 64'h0);
        check("zero_arr_z", {32'h0, z_rd[63:32]}, 64'hFFFF_FFFF);
        a_idle(); a_wr(1, 7'd0, 32'h0F0F_0F0F); a_rd_all(7'd0);
        step();
        check("zero_p1w_a", {32'h0, a_rd[31:0]}, 64'h0);
        check("zero_p1w_z", {32'h0, z_rd[31:0]}, 64'h0F0F_0F0F);

        // Hold while readEn is low
        a_idle(); a_rd_all(7'd3);
        step();
        check("hold_pre", {32'h0, a_rd[31:0]}, 64'h1234_5678);
        a_idle(); a_wr(0, 7'd3, 32'hCAFE_BABE); a_ra = {7'd3, 7'd3};
        step();
        a_idle(); a_ra = {7'd3, 7'd3};
        step();
        check("hold_p0", {32'h0, a_rd[31:0]}, 64'h1234_5678);
        check("hold_p1", {32'h0, a_rd[63:32]}, 64'h1234_5678);
        a_idle(); a_re = 2'b11; a_ra = {7'd9, 7'd3};
        step();
        check("indep_p0", {32'h0, a_rd[31:0]}, 64'hCAFE_BABE);
        check("indep_p1", {32'h0, a_rd[63:32]}, 64'h2222_2222);

        // Wide configuration: basic, bypass, collision
        w_wr(0, 5'd3, 64'h0123_4567_89AB_CDEF);
        step();
        w_idle(); w_rd_all(5'd3);
        step();
        w_check("w_basic", 64'h0123_4567_89AB_CDEF);
        w_idle(); w_wr(1, 5'd7, 64'hA5A5_A5A5_5A5A_5A5A); w_rd_all(5'd7);
        step();
        w_check("w_bypass", 64'hA5A5_A5A5_5A5A_5A5A);
        w_idle(); w_wr(0, 5'd9, 64'h1111_1111_1111_1111); w_wr(1, 5'd9, 64'h2222_2222_2222_2222);
        w_rd_all(5'd9);
        step();
        w_check("w_coll_byp", 64'h2222_2222_2222_2222);
        w_idle(); w_rd_all(5'd9);
        step();
        w_check("w_coll_arr", 64'h2222_2222_2222_2222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
